// File: rtl/lvds_lane_align_ctrl_pkg.sv
// lvds_lane_align_ctrl_pkg: shared state encoding and default constants for the lane aligner
package lvds_lane_align_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_VERIFY,
        ST_LOCKED,
        ST_FAIL
    } state_e;

    localparam int             DEF_N_LANES          = 4;
    localparam logic [7:0]     DEF_TRAINING_PATTERN = 8'hF0;
    localparam int             DEF_LOCK_COUNT       = 64;
    localparam int             DEF_VERIFY_CYCLES    = 256;
    localparam int             DEF_MAX_SLIPS        = 16;
    localparam int             DEF_MAX_RETRIES      = 3;

endpackage

// File: rtl/lvds_lane_align_ctrl_lane_mon.sv
// lane_align_mon: per-lane match-run and bitslip counters; reports next-cycle enable/aligned/failed
module lane_align_mon
    import lvds_lane_align_ctrl_pkg::*;
#(
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int MAX_SLIPS  = DEF_MAX_SLIPS
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic active,
    input  logic match,
    input  logic bs,
    output logic en,
    output logic aligned,
    output logic failed
);

    localparam int RW = $clog2(LOCK_COUNT + 1);
    localparam int SW = $clog2(MAX_SLIPS + 2);
    localparam logic [RW-1:0] RUN_MAX  = RW'(LOCK_COUNT);
    localparam logic [SW-1:0] SLIP_MAX = SW'(MAX_SLIPS);

    logic [RW-1:0] run_q, run_d;
    logic [SW-1:0] slip_q, slip_d;

    // Outputs are next-state views so the controller can act on the same edge the counters update
    assign aligned = run_d == RUN_MAX;
    assign failed  = slip_d > SLIP_MAX;
    assign en      = !aligned && !failed;

    // Run counter restarts on any mismatch; slip counter saturates one past the limit
    always_comb begin
        run_d  = clr ? '0 : !active ? run_q : !match ? '0 : (run_q == RUN_MAX) ? run_q : run_q + RW'(1);
        slip_d = clr ? '0 : (active && bs && slip_q <= SLIP_MAX) ? slip_q + SW'(1) : slip_q;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= '0;
            slip_q <= '0;
        end else begin
            run_q  <= run_d;
            slip_q <= slip_d;
        end
    end

endmodule

// File: rtl/lvds_lane_align_ctrl.sv
// lvds_lane_align_ctrl: training sequencer that aligns all LVDS lanes, verifies them, then passes samples
module lvds_lane_align_ctrl
    import lvds_lane_align_ctrl_pkg::*;
#(
    parameter int         N_LANES          = DEF_N_LANES,
    parameter logic [7:0] TRAINING_PATTERN = DEF_TRAINING_PATTERN,
    parameter int         LOCK_COUNT       = DEF_LOCK_COUNT,
    parameter int         VERIFY_CYCLES    = DEF_VERIFY_CYCLES,
    parameter int         MAX_SLIPS        = DEF_MAX_SLIPS,
    parameter int         MAX_RETRIES      = DEF_MAX_RETRIES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*N_LANES-1:0]   lane_data,
    input  logic [N_LANES-1:0]     lane_bs,
    output logic [N_LANES-1:0]     bitslip_en,
    output logic                   busy,
    output logic                   locked,
    output logic                   fail,
    output logic [N_LANES-1:0]     fail_lanes,
    output logic [8*N_LANES-1:0]   sample_data,
    output logic                   sample_valid
);

    localparam int VW = $clog2(VERIFY_CYCLES + 1);
    localparam int TW = $clog2(MAX_RETRIES + 1);
    localparam logic [VW-1:0] VERIFY_LAST = VW'(VERIFY_CYCLES - 1);
    localparam logic [TW-1:0] RETRY_MAX   = TW'(MAX_RETRIES);

    state_e                 state_q, state_d;
    logic [VW-1:0]          verify_q, verify_d;
    logic [TW-1:0]          retry_q, retry_d;
    logic [N_LANES-1:0]     fail_lanes_q, fail_lanes_d;
    logic [N_LANES-1:0]     bs_en_q;
    logic [8*N_LANES-1:0]   sample_data_q;
    logic                   sample_valid_q;
    logic [N_LANES-1:0]     match, lane_en, lane_aligned, lane_failed;
    logic                   clr;

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        assign match[k] = lane_data[8*k +: 8] == TRAINING_PATTERN;
        lane_align_mon #(
            .LOCK_COUNT (LOCK_COUNT),
            .MAX_SLIPS  (MAX_SLIPS)
        ) u_mon (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr),
            .active  (state_q == ST_ALIGN),
            .match   (match[k]),
            .bs      (lane_bs[k]),
            .en      (lane_en[k]),
            .aligned (lane_aligned[k]),
            .failed  (lane_failed[k])
        );
    end

    // Next-state, retry/verify counting and lane-clear decisions
    always_comb begin
        state_d      = state_q;
        verify_d     = verify_q;
        retry_d      = retry_q;
        fail_lanes_d = fail_lanes_q;
        clr          = 1'b0;
        case (state_q)
            ST_IDLE, ST_LOCKED, ST_FAIL: begin
                if (start) begin
                    state_d      = ST_ALIGN;
                    clr          = 1'b1;
                    retry_d      = '0;
                    verify_d     = '0;
                    fail_lanes_d = '0;
                end
            end
            ST_ALIGN: begin
                fail_lanes_d = lane_failed;
                if (|lane_failed) begin
                    state_d = ST_FAIL;
                end else if (&lane_aligned) begin
                    state_d  = ST_VERIFY;
                    verify_d = '0;
                end
            end
            ST_VERIFY: begin
                if (&match) begin
                    state_d  = (verify_q == VERIFY_LAST) ? ST_LOCKED : ST_VERIFY;
                    verify_d = verify_q + VW'(1);
                end else if (retry_q == RETRY_MAX) begin
                    state_d      = ST_FAIL;
                    fail_lanes_d = ~match;
                end else begin
                    state_d = ST_ALIGN;
                    retry_d = retry_q + TW'(1);
                    clr     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            verify_q       <= '0;
            retry_q        <= '0;
            fail_lanes_q   <= '0;
            bs_en_q        <= '0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            verify_q       <= verify_d;
            retry_q        <= retry_d;
            fail_lanes_q   <= fail_lanes_d;
            bs_en_q        <= (state_d == ST_ALIGN) ? lane_en : '0;
            sample_valid_q <= (state_q == ST_LOCKED) && (state_d == ST_LOCKED);
            if (state_q == ST_LOCKED) sample_data_q <= lane_data;
        end
    end

    assign bitslip_en   = bs_en_q;
    assign busy         = (state_q == ST_ALIGN) || (state_q == ST_VERIFY);
    assign locked       = state_q == ST_LOCKED;
    assign fail         = state_q == ST_FAIL;
    assign fail_lanes   = fail_lanes_q;
    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_lvds_lane_align_ctrl.sv
// tb_lvds_lane_align_ctrl: directed checks of alignment, slip failure, retries, lock and reset
module tb_lvds_lane_align_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] lane_data = '0;
    logic [3:0]  lane_bs = '0;
    logic [3:0]  bitslip_en;
    logic        busy, locked, fail, sample_valid;
    logic [3:0]  fail_lanes;
    logic [31:0] sample_data;

    int n_chk = 0;
    int n_bad = 0;

    localparam logic [31:0] ALL_P = 32'hF0F0F0F0;

    lvds_lane_align_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .lane_data    (lane_data),
        .lane_bs      (lane_bs),
        .bitslip_en   (bitslip_en),
        .busy         (busy),
        .locked       (locked),
        .fail         (fail),
        .fail_lanes   (fail_lanes),
        .sample_data  (sample_data),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("rst_outs", {bitslip_en, fail_lanes, busy, locked, fail, sample_valid}, 32'h0);
        chk("rst_sample", sample_data, 32'h0);
        rst = 1'b0;

        // 1: all lanes present the pattern
        lane_data = ALL_P;
        pulse_start;
        chk("t1_busy", busy, 1);
        chk("t1_en_start", bitslip_en, 4'b1111);
        tick(63);
        chk("t1_en_63", bitslip_en, 4'b1111);
        tick();
        chk("t1_en_verify", bitslip_en, 4'b0000);
        chk("t1_busy_verify", busy, 1);
        tick(255);
        chk("t1_not_locked", locked, 0);
        tick();
        chk("t1_locked", locked, 1);
        chk("t1_valid_entry", sample_valid, 0);
        tick();
        chk("t1_valid", sample_valid, 1);

        // 5: sampling in LOCKED, then restart
        lane_data = 32'h12345678;
        tick();
        chk("t5_sample", sample_data, 32'h12345678);
        chk("t5_valid", sample_valid, 1);
        pulse_start;
        chk("t5_busy", busy, 1);
        chk("t5_valid_drop", sample_valid, 0);
        chk("t5_locked_drop", locked, 0);
        chk("t5_en", bitslip_en, 4'b1111);

        // 6: start in ALIGN ignored, then reset mid-ALIGN
        pulse_start;
        chk("t6_start_ign_busy", busy, 1);
        chk("t6_start_ign_en", bitslip_en, 4'b1111);
        do_reset;
        chk("t6_rst_outs", {bitslip_en, fail_lanes, busy, locked, fail, sample_valid}, 32'h0);
        chk("t6_rst_sample", sample_data, 32'h0);

        // 2: lane 2 needs three bitslips before it matches
        lane_data = {8'hF0, 8'h3C, 8'hF0, 8'hF0};
        pulse_start;
        for (int i = 0; i < 3; i++) begin
            lane_bs = 4'b0100;
            tick();
            lane_bs = 4'b0000;
            tick();
        end
        lane_data = ALL_P;
        tick(59);
        chk("t2_en_lane2_only", bitslip_en, 4'b0100);
        tick(4);
        chk("t2_en_lane2_late", bitslip_en, 4'b0100);
        tick();
        chk("t2_en_verify", bitslip_en, 4'b0000);
        tick(256);
        chk("t2_locked", locked, 1);
        chk("t2_fail_lanes", fail_lanes, 4'b0000);

        // 3: lane 1 never matches and exceeds the slip budget
        do_reset;
        lane_data = {8'hF0, 8'hF0, 8'h00, 8'hF0};
        pulse_start;
        lane_bs = 4'b0010;
        tick(16);
        chk("t3_no_fail_16", fail, 0);
        chk("t3_en_16", bitslip_en, 4'b1111);
        tick();
        lane_bs = 4'b0000;
        chk("t3_fail", fail, 1);
        chk("t3_fail_lanes", fail_lanes, 4'b0010);
        chk("t3_en_off", bitslip_en, 4'b0000);
        chk("t3_busy", busy, 0);
        pulse_start;
        chk("t3_restart_clear", fail_lanes, 4'b0000);
        chk("t3_restart_busy", busy, 1);

        // 4: lane 0 glitches once per VERIFY pass until retries run out
        do_reset;
        lane_data = ALL_P;
        pulse_start;
        for (int r = 0; r < 4; r++) begin
            tick(64);
            chk("t4_verify_en", bitslip_en, 4'b0000);
            tick(10);
            lane_data = {8'hF0, 8'hF0, 8'hF0, 8'h0F};
            tick();
            lane_data = ALL_P;
            if (r < 3) begin
                chk("t4_retry_busy", busy, 1);
                chk("t4_retry_en", bitslip_en, 4'b1111);
            end else begin
                chk("t4_fail", fail, 1);
                chk("t4_fail_lanes", fail_lanes, 4'b0001);
                chk("t4_busy", busy, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
